// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD window controller: loads an IMG_W x IMG_H image byte-serially,
// moves/mirrors a WIN x WIN window on command and streams it after every command.
module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N    = IMG_W * IMG_H;
    localparam int AW   = (N > 1) ? $clog2(N) : 1;
    localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int OW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int CW   = (WIN > 1) ? $clog2(WIN) : 1;

    localparam logic [OW-1:0] X0    = OW'((IMG_W - WIN + 1) / 2);
    localparam logic [OW-1:0] Y0    = OW'((IMG_H - WIN + 1) / 2);
    localparam logic [OW-1:0] XMAX  = OW'(IMG_W - WIN);
    localparam logic [OW-1:0] YMAX  = OW'(IMG_H - WIN);
    localparam logic [CW-1:0] CLAST = CW'(WIN - 1);
    localparam logic [AW-1:0] ALAST = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CAL, DISPLAY} state_t;
    typedef enum logic [2:0] {
        CMD_REFLASH, CMD_LOAD, CMD_RIGHT, CMD_LEFT,
        CMD_UP, CMD_DOWN, CMD_MIRROR, CMD_HOME
    } cmd_t;

    state_t          state, next_state;
    cmd_t            cmd_in, cmd_q;
    logic [DW-1:0]   mem [N];
    logic [AW-1:0]   addr;
    logic [OW-1:0]   ox, oy;
    logic            mirror;
    logic [CW-1:0]   row, col, col_eff;
    logic            pix_done;
    logic [AW-1:0]   pix_addr;

    assign cmd_in = cmd_t'(cmd);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_in == CMD_LOAD)         next_state = LOAD;
                    else if (cmd_in == CMD_REFLASH) next_state = DISPLAY;
                    else                            next_state = CAL;
                end
            end
            LOAD:    if (addr == ALAST) next_state = DISPLAY;
            CAL:     next_state = DISPLAY;
            DISPLAY: if (pix_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Every term stays below N, so the address-width arithmetic never wraps.
    always_comb begin
        col_eff  = mirror ? (CLAST - col) : col;
        pix_addr = (AW'(oy) + AW'(row)) * AW'(IMG_W) + AW'(ox) + AW'(col_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: image words are cleared by reset, so this array is a register file rather than a RAM macro.
            for (int i = 0; i < N; i++) mem[i] <= '0;
            addr         <= '0;
            ox           <= X0;
            oy           <= Y0;
            mirror       <= 1'b0;
            row          <= '0;
            col          <= '0;
            pix_done     <= 1'b0;
            cmd_q        <= CMD_REFLASH;
            dataout      <= '0;
            output_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        busy     <= 1'b1;
                        cmd_q    <= cmd_in;
                        addr     <= '0;
                        row      <= '0;
                        col      <= '0;
                        pix_done <= 1'b0;
                    end
                end
                LOAD: begin
                    mem[addr] <= datain;
                    if (addr == ALAST) begin
                        addr   <= '0;
                        ox     <= X0;
                        oy     <= Y0;
                        mirror <= 1'b0;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                CAL: begin
                    case (cmd_q)
                        CMD_RIGHT:  if (ox < XMAX) ox <= ox + OW'(1);
                        CMD_LEFT:   if (ox != '0)  ox <= ox - OW'(1);
                        CMD_UP:     if (oy != '0)  oy <= oy - OW'(1);
                        CMD_DOWN:   if (oy < YMAX) oy <= oy + OW'(1);
                        CMD_MIRROR: mirror <= ~mirror;
                        CMD_HOME: begin
                            ox <= X0;
                            oy <= Y0;
                        end
                        default: ;
                    endcase
                end
                DISPLAY: begin
                    // One extra cycle after the last pixel drops valid and busy on the same edge.
                    if (pix_done) begin
                        output_valid <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        dataout      <= mem[pix_addr];
                        output_valid <= 1'b1;
                        if (col == CLAST) begin
                            col <= '0;
                            if (row == CLAST) pix_done <= 1'b1;
                            else              row <= row + CW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
